segled_serial_driver: RTL
=========================

Name: segled_serial_driver

Overview:
Parallel-to-serial driver that feeds the on-board 7-segment shift-register chain. It sits between the display-pattern logic inside top and the SEGLED_CLK / SEGLED_DO / SEGLED_PEN pins. It accepts a DATA_W-bit segment pattern on a start strobe, shifts it out MSB first on a divided serial clock, then re-enables the display. It is also reusable for the LED_CLK / LED_DO / LED_PEN chain with DATA_W=16.

Parameters:
DATA_W, 64, pattern width in bits (number of serial bits per frame); legal range 2..256
HALF, 2, clk cycles per sclk half-period; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
data  input  DATA_W  segment pattern; sampled only on the accepting start cycle
start  input  1  frame request; accepted only in IDLE
busy  output  1  high from the cycle after acceptance until frame complete
done  output  1  one-cycle pulse at frame completion
sclk  output  1  serial shift clock, to SEGLED_CLK
sdo  output  1  serial data, to SEGLED_DO
pen  output  1  display enable, to SEGLED_PEN; 1 = shown, 0 = blanked during shift

Behaviour:
- Reset (async, rstn=0): state=IDLE; busy=0, done=0, sclk=0, sdo=0, pen=0. Internal shift register, bit counter and divider counter are all cleared. Reset mid-frame aborts immediately; the next frame starts from scratch.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - On start=1, next edge: state=SHIFT, shreg<=data, bitcnt<=0, div<=0, sclk<=0, sdo<=data[DATA_W-1], pen<=0, busy<=1.
  - start=0: all outputs hold; done is 0.
- SHIFT:
  - div counts 0..HALF-1 and wraps.
  - On div==HALF-1 with sclk=0: sclk<=1 (rising edge; receiver samples sdo here).
  - On div==HALF-1 with sclk=1: sclk<=0, shreg<<=1, sdo<=next bit, bitcnt<=bitcnt+1.
  - If bitcnt==DATA_W-1 at that falling edge: state=LATCH, sclk<=0, sdo holds, no further shift.
  - sdo changes only at falling sclk edges, so it is stable a full half-period before each rising edge.
- LATCH (one cycle): pen<=1, done<=1, busy<=0, state=IDLE. done is cleared the following cycle.
- Latency: busy is high for exactly DATA_W*2*HALF + 1 cycles. done appears DATA_W*2*HALF + 1 cycles after the accepting start edge. Exactly DATA_W rising sclk edges per frame.
- start while busy or in LATCH: ignored, not queued.
- start held high: a new frame is accepted on the first IDLE cycle, i.e. the cycle after done. pen then drops again.
- data changes during SHIFT: no effect, because the pattern is captured in shreg.
- Widths: bitcnt is $clog2(DATA_W) bits; div is max(1,$clog2(HALF)) bits; the bitcnt comparison is done at full counter width.
- pen stays 1 in IDLE after the first completed frame; it is 0 only during SHIFT and after reset.

Decomposition:
- Shared package seg_pkg:
  - state typedef (IDLE/SHIFT/LATCH, 2-bit encoding)
  - SEG_FRAME_W=64, LED_FRAME_W=16 constants
- One natural sub-module: segled_tick_gen, the HALF-cycle divider producing the div==HALF-1 tick. It is enabled only in SHIFT and cleared on acceptance.
- FSM, shift register and counters stay in segled_serial_driver.

Test Plan:
- Reset check: rstn=0 held 95 ns with clk toggling -> busy=0, done=0, sclk=0, sdo=0, pen=0. Release -> outputs unchanged.
- DATA_W=8, HALF=2, data=8'hA5, 1-cycle start:
  - sdo sampled at the 8 sclk rising edges = 1,0,1,0,0,1,0,1
  - busy high exactly 33 cycles
  - done a single pulse on the cycle busy falls
  - pen 0 during shift, then 1
- Default DATA_W=64, HALF=2, data=64'hFFFF_0000_1234_ABCD:
  - 64 rising sclk edges
  - captured serial word equals data
  - done 257 cycles after acceptance
- start pulsed at cycle 10 of an active frame, with data changed to all zeros -> ignored; shifted word is still the original value and only one done pulse occurs.
- start held high continuously:
  - frames run back-to-back
  - pen reads 1 for exactly one cycle (IDLE) between frames
  - second frame begins the cycle after done
- rstn asserted mid-frame at bit 30 -> all outputs 0 within the same cycle. After release, start with 8'h3C (DATA_W=8) -> clean frame 0,0,1,1,1,1,0,0 with no residue from the aborted frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the segment/LED serial chain drivers.
//   state_t      : driver FSM state (IDLE / SHIFT / LATCH, 2-bit encoding)
//   SEG_FRAME_W  : frame width of the 7-segment shift-register chain
//   LED_FRAME_W  : frame width of the discrete LED shift-register chain
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int SEG_FRAME_W = 64;
    localparam int LED_FRAME_W = 16;

endpackage

// File: rtl/segled_tick_gen.sv
// Half-period divider for the serial shift clock.
// Counts 0..HALF-1 while enabled and flags the last count with a tick.
// Ports:
//   clk    : system clock, rising edge
//   rstn   : asynchronous active-low reset
//   en_i   : count enable (driver is shifting)
//   clr_i  : synchronous clear (frame accepted)
//   tick_o : high on the cycle the counter sits at HALF-1 while enabled
module segled_tick_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] LAST = DW'(HALF - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = en_i && (div_q == LAST);

endmodule

// File: rtl/segled_serial_driver.sv
// Parallel-to-serial driver for a shift-register display chain.
// Captures a DATA_W-bit pattern on start, shifts it out MSB first on a
// divided serial clock with the display blanked, then re-enables it.
// Ports:
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   data  : pattern, sampled on the accepting start cycle only
//   start : frame request, honoured only in IDLE
//   busy  : high from the cycle after acceptance until frame complete
//   done  : one-cycle pulse at frame completion
//   sclk  : serial shift clock
//   sdo   : serial data, changes only on falling sclk
//   pen   : display enable (0 while shifting and after reset)
module segled_serial_driver
    import seg_pkg::*;
#(
    parameter int DATA_W = SEG_FRAME_W,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sdo,
    output logic              pen
);

    localparam int BCW = $clog2(DATA_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0]      bitcnt_q, bitcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sclk_q, sclk_d;
    logic                sdo_q, sdo_d;
    logic                pen_q, pen_d;
    logic                accept;
    logic                tick;

    segled_tick_gen #(.HALF(HALF)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (state_q == SHIFT),
        .clr_i  (accept),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sclk_d   = sclk_q;
        sdo_d    = sdo_q;
        pen_d    = pen_q;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_d  = SHIFT;
                    shreg_d  = data;
                    bitcnt_d = '0;
                    sclk_d   = 1'b0;
                    sdo_d    = data[DATA_W-1];
                    pen_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // Last falling edge: the final bit has been sampled,
                        // so sdo holds and no further shift is needed.
                        if (bitcnt_q == LAST_BIT) begin
                            state_d = LATCH;
                        end else begin
                            // Next bit is the one just below the current MSB.
                            sdo_d    = shreg_q[DATA_W-2];
                            shreg_d  = shreg_q << 1;
                            bitcnt_d = bitcnt_q + BCW'(1);
                        end
                    end
                end
            end
            LATCH: begin
                pen_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
            pen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
            pen_q    <= pen_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sclk = sclk_q;
    assign sdo  = sdo_q;
    assign pen  = pen_q;

endmodule
